// File: rtl/sorted_stream_merge.sv
// Two-way merge of independently sorted signed frames into one sorted frame, registered output.
// Optional input-order checker enabled by defining SORTED_STREAM_MERGE_ORDER_CHECK_EN.
module sorted_stream_merge #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [width-1:0] a_data,
  input  logic             a_last,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [width-1:0] b_data,
  input  logic             b_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             out_last,
  output logic             order_err
);

  // Handshake: a word moves on a port in any cycle where valid && ready.
  // Readies never look at other readies; they follow state, valids, data and out_ready.
  typedef enum logic [1:0] {BOTH, ONLY_A, ONLY_B} state_t;

  state_t state, state_next;
  logic   load;
  logic   a_fire, b_fire;

  assign load   = !out_valid || out_ready;
  assign a_fire = a_valid && a_ready;
  assign b_fire = b_valid && b_ready;

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state)
      BOTH: begin
        // Ties favour A so equal keys keep their A-before-B order.
        if (a_valid && b_valid && load) begin
          if ($signed(a_data) <= $signed(b_data)) a_ready = 1'b1;
          else                                    b_ready = 1'b1;
        end
      end
      ONLY_A:  a_ready = load;
      ONLY_B:  b_ready = load;
      default: ;
    endcase
    if (!rst_n) begin
      a_ready = 1'b0;
      b_ready = 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BOTH: begin
        if (a_fire && a_last)      state_next = ONLY_B;
        else if (b_fire && b_last) state_next = ONLY_A;
      end
      ONLY_A:  if (a_fire && a_last) state_next = BOTH;
      ONLY_B:  if (b_fire && b_last) state_next = BOTH;
      default: state_next = BOTH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOTH;
    else        state <= state_next;
  end

  // Merged frame ends only when the second input frame finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= a_fire || b_fire;
      if (a_fire) begin
        out_data <= a_data;
        out_last <= (state == ONLY_A) && a_last;
      end else if (b_fire) begin
        out_data <= b_data;
        out_last <= (state == ONLY_B) && b_last;
      end
    end
  end

`ifdef SORTED_STREAM_MERGE_ORDER_CHECK_EN
  logic [width-1:0] a_prev, b_prev;
  logic             a_first, b_first;

  // First word of each frame has no predecessor to compare against.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_prev    <= '0;
      b_prev    <= '0;
      a_first   <= 1'b1;
      b_first   <= 1'b1;
      order_err <= 1'b0;
    end else begin
      if (a_fire) begin
        a_prev  <= a_data;
        a_first <= a_last;
        if (!a_first && ($signed(a_data) < $signed(a_prev))) order_err <= 1'b1;
      end
      if (b_fire) begin
        b_prev  <= b_data;
        b_first <= b_last;
        if (!b_first && ($signed(b_data) < $signed(b_prev))) order_err <= 1'b1;
      end
    end
  end
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: doc/sorted_stream_merge.md
# sorted_stream_merge

Streaming two-way merge unit that sits downstream of the pipelined sorter stages. It consumes two independently sorted frames of signed words, A and B, each delimited by a `last` flag, and emits a single sorted frame containing every element of both. Each input and the output use a valid/ready handshake. The output is registered, giving one element per cycle at full throughput.

## Interface
Parameters:
- `width`, 32, data word width; values compared as two's-complement signed.

Ports:
- `clk`  input  1  sole clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `a_valid`  input  1  stream A word present.
- `a_ready`  output  1  stream A word accepted this cycle.
- `a_data`  input  `width`  stream A word.
- `a_last`  input  1  final word of the A frame.
- `b_valid`, `b_ready`, `b_data`, `b_last`: same as the A ports, for stream B.
- `out_valid`  output  1  merged word present.
- `out_ready`  input  1  downstream accepts.
- `out_data`  output  `width`  merged word.
- `out_last`  output  1  final word of the merged frame.
- `order_err`  output  1  sticky input-order violation flag (see Configuration).

## Operation
- Transfer on any port occurs when valid && ready.
- The output register loads when `load = !out_valid || out_ready`.
- FSM states: BOTH (reset state), ONLY_A, ONLY_B.
- **BOTH** state:
  - A selection is made only when `a_valid && b_valid` and `load`.
  - Select A if `$signed(a_data) <= $signed(b_data)`, otherwise select B. Ties go to A, which keeps the merge stable.
  - Only the selected input's ready is asserted; the other ready stays 0.
  - If A is taken with `a_last`, go to ONLY_B.
  - If B is taken with `b_last`, go to ONLY_A.
  - The output `out_last` is 0 for every word taken in BOTH.
- **ONLY_A** state:
  - `a_ready = load`; B is never ready.
  - Each taken A word passes through unchanged.
  - When A is taken with `a_last`: set `out_last` = 1 and go to BOTH.
- **ONLY_B** state: mirror of ONLY_A.
- Single-word frames (last on the first word) are legal.
- The `ready` outputs may depend combinationally on `valid`, data, and `out_ready`. No `ready` depends on another `ready`.
- Input `last` flags are consumed only through the FSM. A stream's next frame is not accepted until the merged frame completes.

## Timing
- Reset (async assert, sync release): FSM = BOTH, `out_valid` = 0, `out_data` = 0, `out_last` = 0, `order_err` = 0. Both `ready` outputs are 0 while `rst_n` is low.
- Latency: a word accepted at edge N appears on `out_data` with `out_valid` = 1 after edge N.
- Throughput: 1 word/cycle while `out_ready` = 1 and the required inputs are valid.
- Backpressure:
  - With `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_last` hold and both input `ready` signals are 0.
  - With `out_ready` = 1, a new word may load in the same cycle the held word leaves (no bubble).
- Stall in BOTH: if only one input is valid, nothing transfers and `out_valid` falls after the pending word drains.
- Reset mid-frame discards partial frame state and the held output word.

## Configuration
- Macro: `SORTED_STREAM_MERGE_ORDER_CHECK_EN`.
- **Defined:** the block keeps a per-stream previous-word register and a first-of-frame flag.
  - A taken word that is not first-of-frame and is `$signed` less than that stream's previous word sets `order_err` on the next edge.
  - `order_err` stays set until reset.
  - The merge itself is unaffected.
- **Undefined:** the check logic is absent and `order_err` is tied to 0.

## Test plan
- **Basic merge:** A = {-5, 0, 7(last)}, B = {-2, 7, 9(last)}, `out_ready` = 1 -> out = -5, -2, 0, 7(A), 7(B), 9 with `out_last` only on 9; 6 consecutive valid cycles after the first load.
- **Tie stability:** A = {3, 3(last)}, B = {3(last)} -> both A 3s emitted before the B 3; `b_ready` stays 0 until A finishes.
- **Drain and single-word frame:** A = {100(last)}, B = {1, 2, 200, 300(last)} -> 1, 2, 100, then ONLY_B gives 200, 300(last); FSM returns to BOTH.
- **Backpressure:** random `out_ready` (50%) over 1000 random sorted frame pairs -> output matches the reference merge, no drop or duplicate, and data/last stay stable while stalled.
- **Order check (macro defined):** A = {5, 2(last)} -> `order_err` = 1 the cycle after 2 is taken and stays high across later clean frames. With the macro undefined, `order_err` stays 0.
- **Reset mid-frame:** assert `rst_n` = 0 after 2 of 4 words -> `out_valid` drops immediately; a fresh frame pair after release merges correctly from BOTH.
